// File: rtl/slot_pkg.sv
// ---------------------------------------------------------------------------
// slot_pkg
// Definitions shared by the reel start sequencer and the per-reel spin
// counters: the sequencer state encoding and the default reel count and
// inter-reel start delay of the standard three-reel cabinet.
// No ports (package).
// ---------------------------------------------------------------------------
package slot_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int REEL_COUNT  = 3;
  localparam int START_DELAY = 7;

endpackage

// File: rtl/reel_start_sequencer_interval_counter.sv
// ---------------------------------------------------------------------------
// interval_counter
// Spacing counter for the reel start sequencer. Loading forces the count to
// 1 (the cycle of a reel pulse counts as the first cycle of the interval);
// the count then advances while enabled. o_term is high while the count
// equals DELAY, i.e. in the last cycle before the next pulse is due. The
// owner never enables counting past DELAY, so the count never wraps.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous active-low reset (count cleared to 0)
//   i_load  in   load count with 1 (has priority over i_en)
//   i_en    in   advance count by one
//   o_term  out  count == DELAY
// ---------------------------------------------------------------------------
module interval_counter
  import slot_pkg::*;
#(
  parameter int DELAY = START_DELAY
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_term
);

  localparam int CW = $clog2(DELAY + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_term = (r_cnt == CW'(DELAY));

endmodule

// File: rtl/reel_start_sequencer.sv
// ---------------------------------------------------------------------------
// reel_start_sequencer
// Staggers the start of NUM_REELS slot reels after a single start request.
// On an accepted start the enable mask is latched and every enabled reel,
// lowest index first, receives a one-cycle start pulse; consecutive pulses
// are DELAY clocks apart and disabled reels are skipped without using a
// delay slot. done pulses together with the last reel pulse (or alone, one
// cycle after the start, when the mask is empty). abort cancels a running
// sequence and wins over a simultaneous start. With RETRIGGER=1 a start
// while busy restarts the sequence from the newly latched mask.
// All outputs come straight from registers.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   start request (level, sampled every edge)
//   abort       in   synchronous cancel of a running sequence
//   reel_en     in   per-reel enable mask, bit 0 = first reel
//   reel_start  out  one-hot one-cycle start pulse per reel
//   busy        out  sequence in progress
//   done        out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module reel_start_sequencer
  import slot_pkg::*;
#(
  parameter int NUM_REELS = REEL_COUNT,
  parameter int DELAY     = START_DELAY,
  parameter int RETRIGGER = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_REELS-1:0] reel_en,
  output logic [NUM_REELS-1:0] reel_start,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REELS-1:0] r_mask;
  logic [NUM_REELS-1:0] w_mask_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [NUM_REELS-1:0] r_reel_start;
  logic [NUM_REELS-1:0] w_reel_start_nxt;
  logic                 r_done;
  logic                 w_done_nxt;

  logic                 w_cnt_load;
  logic                 w_cnt_en;
  logic                 w_cnt_term;

  logic                 w_accept;
  logic                 w_first_found;
  logic                 w_first_last;
  logic [IW-1:0]        w_first_idx;
  logic                 w_next_found;
  logic                 w_next_last;
  logic [IW-1:0]        w_next_idx;

  interval_counter #(
    .DELAY (DELAY)
  ) u_interval (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_term (w_cnt_term)
  );

  // Lowest enabled reel of the incoming mask, and whether it is also the
  // highest one (a single-reel sequence finishes in its first pulse cycle).
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    for (int i = NUM_REELS - 1; i >= 0; i--) begin
      if (reel_en[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = IW'(i);
      end
    end
    w_first_last = w_first_found;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (reel_en[i] && (i > int'(w_first_idx))) begin
        w_first_last = 1'b0;
      end
    end
  end

  // Next enabled reel strictly above the one that pulsed last, searched in
  // the latched mask so reel_en changes mid-sequence have no effect.
  always_comb begin
    w_next_found = 1'b0;
    w_next_idx   = '0;
    for (int i = NUM_REELS - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_idx))) begin
        w_next_found = 1'b1;
        w_next_idx   = IW'(i);
      end
    end
    w_next_last = w_next_found;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (r_mask[i] && (i > int'(w_next_idx))) begin
        w_next_last = 1'b0;
      end
    end
  end

  assign w_accept = start && !abort &&
                    ((r_state == IDLE) || (RETRIGGER != 0));

  always_comb begin
    w_state_nxt      = r_state;
    w_mask_nxt       = r_mask;
    w_idx_nxt        = r_idx;
    w_reel_start_nxt = '0;
    w_done_nxt       = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_en         = 1'b0;

    if ((r_state == RUN) && abort) begin
      w_state_nxt = IDLE;
    end else if (w_accept) begin
      w_mask_nxt = reel_en;
      if (w_first_found) begin
        w_reel_start_nxt = NUM_REELS'(1) << w_first_idx;
        w_idx_nxt        = w_first_idx;
        w_cnt_load       = 1'b1;
        if (w_first_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end else begin
        // Empty mask: nothing to start, report completion at once.
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
    end else if (r_state == RUN) begin
      if (w_cnt_term) begin
        if (w_next_found) begin
          w_reel_start_nxt = NUM_REELS'(1) << w_next_idx;
          w_idx_nxt        = w_next_idx;
          w_cnt_load       = 1'b1;
          if (w_next_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          // Unreachable while RUN always has a reel pending; recover cleanly.
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end else begin
        w_cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_reel_start <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_idx        <= w_idx_nxt;
      r_reel_start <= w_reel_start_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign reel_start = r_reel_start;
  assign busy       = (r_state == RUN);
  assign done       = r_done;

endmodule

// File: doc/reel_start_sequencer.md
Name: reel_start_sequencer

Overview:
- Staggers the start of N slot reels after one start request. Each enabled reel receives a one-cycle start pulse, and consecutive pulses are spaced by a fixed number of clocks.
- This is the next generation of the single-stage start-delay timer. It generalises reel count and delay, and adds a per-reel enable mask, abort, retrigger mode and a completion flag.
- It sits between the front-panel start logic and the per-reel spin counters.

Parameters:
- NUM_REELS, 3, number of reels (1..16).
- DELAY, 7, clocks between consecutive reel start pulses (1..255).
- RETRIGGER, 0, 1 = start while busy restarts the sequence; 0 = start while busy is ignored.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  start request, sampled every rising edge; level, not edge-detected.
- abort  input  1  synchronous cancel of any running sequence.
- reel_en  input  NUM_REELS  per-reel enable mask; bit 0 is the first reel.
- reel_start  output  NUM_REELS  one-hot, one-cycle start pulse to each reel.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse on sequence completion.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, latched mask=0. reel_start, busy and done are all 0. Reset mid-sequence drops the sequence; no further pulses occur.
- All outputs are registered, with no combinational input-to-output path.
- States: IDLE and RUN. busy = (state==RUN).
- Counter: cnt has width $clog2(DELAY+1). It is loaded with 1 on every reel pulse and incremented while in RUN. It is never compared beyond DELAY, so it never wraps.
- Start from IDLE: start=1 and abort=0 at edge t:
  - latch reel_en into the mask; the mask is held for the whole sequence, so later reel_en changes are ignored;
  - find the lowest enabled index k;
  - in cycle t+1, reel_start[k]=1 and cnt=1.
  - If k is the only enabled reel: done=1 in the same cycle and state stays IDLE.
  - Otherwise: state=RUN.
- Empty mask: start with reel_en=0 gives no reel_start pulses and done=1 in cycle t+1.
- Advancing in RUN: at the edge where cnt==DELAY:
  - pulse the next higher enabled index (disabled reels are skipped and consume no delay slot);
  - reload cnt=1;
  - if that index is the highest enabled reel, also pulse done and return to IDLE.
- Pulse spacing: consecutive pulses are exactly DELAY cycles apart. For DELAY=1 the pulses fall on consecutive cycles.
- busy timing: busy rises in the first-pulse cycle and is already 0 in the last-pulse/done cycle.
- Abort:
  - abort=1 in RUN: next cycle is IDLE with no pulse and no done.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- Start while RUN:
  - RETRIGGER=0: ignored.
  - RETRIGGER=1: behaves as a start from IDLE; the mask is relatched and the first enabled reel pulses next cycle.
- Output invariants: at most one reel_start bit is high in any cycle. done is never high in two consecutive cycles unless a new start was accepted.

Decomposition:
- Package slot_pkg: the state enum (IDLE, RUN) and the default constants REEL_COUNT=3 and START_DELAY=7, shared with the reel spin counters.
- One sub-module, interval_counter: a parametrised counter with load-to-1 and count-enable that raises a terminal flag at cnt==DELAY.
- Next-enabled-index selection (priority encode above the current index) stays inline in reel_start_sequencer.

Test Plan:
- Basic sequence (NUM_REELS=3, DELAY=7, reel_en=3'b111): start pulse at cycle 0 gives reel_start=001 at cycle 1, 010 at cycle 8, 100 plus done=1 at cycle 15. busy is high in cycles 1..14 and low at 15.
- Skip (reel_en=3'b101): start at cycle 0 gives 001 at cycle 1, then 100 plus done at cycle 8. Empty mask: start gives done at cycle 1 and no pulses.
- Abort at cycle 5 of the basic sequence: busy=0 from cycle 6, with no further reel_start and no done. Abort and start together in the same cycle: abort wins.
- Retrigger:
  - RETRIGGER=0: start at cycle 10 of a running sequence is ignored; the sequence completes at cycle 15.
  - RETRIGGER=1: start at cycle 10 gives 001 at cycle 11, then 010 at 18 and 100 at 25.
- Asynchronous reset asserted mid-cycle at cycle 9: outputs go to 0 immediately. After release, no pulse appears until a new start.
- DELAY=1, reel_en=111: pulses 001, 010, 100 on cycles 1, 2, 3; done at cycle 3. Also randomised masks checked against the one-hot invariant.
